// File: rtl/oven_thermal_model.sv
// Multi-zone oven thermal model.
// Each zone integrates a 2-bit heat command on every update tick. An unheated
// zone cools passively by one degree every COOL_DIV ticks, and every zone loses
// DOOR_LOSS degrees per tick while the door is open. The result is clamped to
// [AMBIENT, MAX_TEMP]. A zone is ready after SETTLE_TICKS consecutive in-band
// ticks, and the oven is preheated once every zone is ready.
module oven_thermal_model #(
    parameter int WIDTH        = 10,
    parameter int ZONES        = 2,
    parameter int AMBIENT      = 65,
    parameter int MAX_TEMP     = 511,
    parameter int TOL          = 2,
    parameter int SETTLE_TICKS = 4,
    parameter int COOL_DIV     = 8,
    parameter int DOOR_LOSS    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    input  logic [WIDTH-1:0]         targetTemp,
    input  logic [2*ZONES-1:0]       heat,
    input  logic                     door_open,
    output logic [ZONES*WIDTH-1:0]   currentTemp,
    output logic [ZONES-1:0]         zoneReady,
    output logic                     preheated,
    output logic                     overheat
);

    localparam int CW = (COOL_DIV > 1) ? $clog2(COOL_DIV) : 1;
    localparam int SW = $clog2(SETTLE_TICKS + 1);
    localparam int XW = WIDTH + 2;

    localparam logic [XW-1:0]  AMB_X  = XW'(AMBIENT);
    localparam logic [XW-1:0]  MAX_X  = XW'(MAX_TEMP);
    localparam logic [XW-1:0]  LOSS_X = XW'(DOOR_LOSS);
    localparam logic [WIDTH:0] TOL_E  = (WIDTH + 1)'(TOL);

    // Saturate a signed intermediate temperature into the legal window.
    function automatic logic [WIDTH-1:0] clamp_temp(input logic [XW-1:0] raw);
        logic [WIDTH-1:0] res;
        if ($signed(raw) < $signed(AMB_X)) begin
            res = WIDTH'(AMBIENT);
        end else if ($signed(raw) > $signed(MAX_X)) begin
            res = WIDTH'(MAX_TEMP);
        end else begin
            res = raw[WIDTH-1:0];
        end
        return res;
    endfunction

    logic [ZONES-1:0][WIDTH-1:0] temp_r;
    logic [ZONES-1:0][CW-1:0]    cool_cnt_r;
    logic [ZONES-1:0][SW-1:0]    settle_r;
    logic [ZONES-1:0]            ready_r;
    logic                        preheated_r;
    logic                        overheat_r;
    logic [WIDTH-1:0]            target_r;

    logic [ZONES-1:0][WIDTH-1:0] temp_nxt_s;
    logic [ZONES-1:0][CW-1:0]    cool_nxt_s;
    logic [ZONES-1:0][SW-1:0]    settle_nxt_s;
    logic [ZONES-1:0]            ready_nxt_s;
    logic [ZONES-1:0][1:0]       heat_z_s;
    logic [ZONES-1:0]            cool_step_s;
    logic [ZONES-1:0]            in_band_s;
    logic [ZONES-1:0][XW-1:0]    sum_s;
    logic                        target_chg_s;
    logic                        all_ready_s;
    logic                        any_max_s;

    // Per-zone next state: temperature integration, cooling cadence, settling.
    always_comb begin
        target_chg_s = (targetTemp != target_r);
        temp_nxt_s   = temp_r;
        cool_nxt_s   = cool_cnt_r;
        settle_nxt_s = settle_r;
        ready_nxt_s  = ready_r;
        for (int z = 0; z < ZONES; z++) begin
            heat_z_s[z]    = heat[2*z +: 2];
            cool_step_s[z] = (heat_z_s[z] == 2'd0) && (cool_cnt_r[z] == CW'(COOL_DIV - 1));
            // Zero-extended to WIDTH+2 bits so a dip below zero reads as negative.
            sum_s[z] = {2'b00, temp_r[z]}
                     + {{WIDTH{1'b0}}, heat_z_s[z]}
                     - {{(XW-1){1'b0}}, cool_step_s[z]}
                     - (door_open ? LOSS_X : {XW{1'b0}});
            // One extra bit keeps target-TOL and target+TOL from wrapping.
            in_band_s[z] = (({1'b0, temp_r[z]} + TOL_E) >= {1'b0, target_r})
                        && ({1'b0, temp_r[z]} <= ({1'b0, target_r} + TOL_E));
            if (tick) begin
                temp_nxt_s[z] = clamp_temp(sum_s[z]);
                if ((heat_z_s[z] != 2'd0) || cool_step_s[z]) begin
                    cool_nxt_s[z] = {CW{1'b0}};
                end else begin
                    cool_nxt_s[z] = cool_cnt_r[z] + CW'(1);
                end
                if (target_chg_s || !in_band_s[z]) begin
                    settle_nxt_s[z] = {SW{1'b0}};
                    ready_nxt_s[z]  = 1'b0;
                end else if (settle_r[z] < SW'(SETTLE_TICKS)) begin
                    settle_nxt_s[z] = settle_r[z] + SW'(1);
                    ready_nxt_s[z]  = ((settle_r[z] + SW'(1)) == SW'(SETTLE_TICKS));
                end else begin
                    settle_nxt_s[z] = settle_r[z];
                    ready_nxt_s[z]  = 1'b1;
                end
            end else if (target_chg_s) begin
                settle_nxt_s[z] = {SW{1'b0}};
                ready_nxt_s[z]  = 1'b0;
            end else begin
                settle_nxt_s[z] = settle_r[z];
                ready_nxt_s[z]  = ready_r[z];
            end
        end
    end

    // Oven-level status derived from the current registered zone state.
    always_comb begin
        all_ready_s = &ready_r;
        any_max_s   = 1'b0;
        for (int z = 0; z < ZONES; z++) begin
            if (temp_r[z] == WIDTH'(MAX_TEMP)) begin
                any_max_s = 1'b1;
            end else begin
                any_max_s = any_max_s;
            end
        end
    end

    // State register; reset wins over tick and reloads the target copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int z = 0; z < ZONES; z++) begin
                temp_r[z]     <= WIDTH'(AMBIENT);
                cool_cnt_r[z] <= {CW{1'b0}};
                settle_r[z]   <= {SW{1'b0}};
            end
            ready_r     <= {ZONES{1'b0}};
            preheated_r <= 1'b0;
            overheat_r  <= 1'b0;
            target_r    <= targetTemp;
        end else begin
            temp_r      <= temp_nxt_s;
            cool_cnt_r  <= cool_nxt_s;
            settle_r    <= settle_nxt_s;
            ready_r     <= ready_nxt_s;
            preheated_r <= all_ready_s;
            overheat_r  <= any_max_s;
            target_r    <= targetTemp;
        end
    end

    assign currentTemp = temp_r;
    assign zoneReady   = ready_r;
    assign preheated   = preheated_r;
    assign overheat    = overheat_r;

endmodule
